fft_frame_writer: RTL and testbench
===================================

# fft_frame_writer

Write-side framing stage that sits directly upstream of the audio-to-FFT asynchronous FIFO in the `clk_write` domain. It accepts a stream of audio samples and groups them into fixed-length FFT frames. It writes a frame into the FIFO only if the FIFO can hold the whole frame; otherwise it drops the whole frame, so the FFT side never receives a partial frame. Each word carries a start-of-frame flag in its MSB.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16: audio sample width.
- `FRAME_LEN_LOG2`, 8: frame length is FRAME_LEN = 2**FRAME_LEN_LOG2 samples.
- `FIFO_DEPTH_WIDTH`, 11: must match the downstream FIFO. Depth = 2**FIFO_DEPTH_WIDTH. Constraint: FRAME_LEN+2 <= depth.

Ports:
- `clk_write`, in, 1: write-domain clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `enable`, in, 1: level. Permits new frames to start.
- `in_valid`, in, 1: sample strobe. May be high every cycle.
- `in_data`, in, SAMPLE_WIDTH: audio sample.
- `fifo_full`, in, 1: FIFO full flag, write-domain.
- `fifo_count`, in, FIFO_DEPTH_WIDTH: FIFO `data_count_w`.
- `fifo_write`, out, 1: FIFO write strobe (registered).
- `fifo_data`, out, SAMPLE_WIDTH+1: {sof, sample} (registered).
- `frames_written`, out, 16: frames accepted. Saturates at 0xFFFF.
- `frames_dropped`, out, 16: frames discarded. Saturates at 0xFFFF.
- `overrun`, out, 1: sticky. Set when a write was issued while `fifo_full`=1.
- `busy`, out, 1: high in WRITE or DROP.

## Operation
- States: IDLE, ARM, WRITE, DROP. A sample index counter `idx` of FRAME_LEN_LOG2 bits tracks position in the frame.
- IDLE:
  - `in_valid` is ignored.
  - Goes to ARM when `enable`=1.
- ARM:
  - If `enable`=0, go to IDLE.
  - Otherwise the first `in_valid` is the frame's sample 0, and the accept decision is made on that cycle.
  - free = 2**FIFO_DEPTH_WIDTH − fifo_count, computed in FIFO_DEPTH_WIDTH+1 bits.
  - Accept iff `fifo_full`=0 AND free >= FRAME_LEN+2.
    - The +2 margin covers the one-cycle lag of the registered count plus this block's own output register.
    - `fifo_full` is checked explicitly because a full FIFO reports count 0 (truncation).
  - Accept: issue a write with sof=1, set idx=1, go to WRITE.
  - Reject: discard the sample, set idx=1, go to DROP.
- WRITE:
  - Each `in_valid` issues a write with sof=0 and increments idx.
  - On the write at idx=FRAME_LEN−1: increment `frames_written`, then go to ARM if `enable`=1, else IDLE.
- DROP:
  - Each `in_valid` is discarded and increments idx.
  - At idx=FRAME_LEN−1: increment `frames_dropped`, then go to ARM if `enable`=1, else IDLE.
  - No FIFO writes occur in DROP.
- `enable` falling mid-frame has no effect until the current frame completes (written or dropped).
- Overrun: `overrun` sets on any edge where `fifo_write`=1 and `fifo_full`=1. The FIFO discards that word, but framing continues unchanged. Only reset clears `overrun`.
- Counters saturate and do not wrap.

## Timing
- Reset values:
  - state=IDLE, idx=0.
  - `fifo_write`=0, `fifo_data`=0.
  - `frames_written`=0, `frames_dropped`=0.
  - `overrun`=0, `busy`=0.
- Latency: `in_valid` at edge N produces `fifo_write`/`fifo_data` valid for the cycle after edge N. This is a one-cycle pipeline with no backpressure.
- `fifo_write` is a single-cycle pulse per accepted sample. Consecutive `in_valid` produce consecutive pulses.
- The frame counters update on the same edge that registers the last sample's write (or discard).
- The accept decision uses `fifo_full`/`fifo_count` sampled at the edge where sample 0 arrives.
- An asynchronous reset mid-frame aborts the frame immediately. No partial-frame recovery is attempted; the downstream stage resynchronises on sof.

## Test plan
- **Reset:** assert `rst_n`=0 mid-WRITE → all outputs at reset values within the same cycle; `fifo_write`=0.
- **Normal frame:** `enable`=1, fifo_count=0, 256 back-to-back samples 0..255 → exactly 256 `fifo_write` pulses. The first pulse has `fifo_data`=0x1_0000 (sof=1); the last has 0x0_00FF. `frames_written`=1.
- **Room boundary:**
  - fifo_count=1790 at sample 0 → frame accepted.
  - fifo_count=1791 → 256 samples produce no writes, `frames_dropped`=1. The next frame at count 0 is written.
- **Full override:** `fifo_full`=1 with fifo_count=0 at sample 0 → frame dropped, no writes.
- **Enable drop mid-frame:** `enable`→0 at sample 100 → all 256 samples are written, then state goes to IDLE. Further `in_valid` produces no writes.
- **Overrun:** force `fifo_full`=1 for one cycle during WRITE → `overrun`=1 and stays 1. The remaining samples are still written, and `frames_written` increments.

Source files
------------

// File: rtl/fft_frame_writer.sv
// Write-side framing stage ahead of the audio-to-FFT async FIFO. Groups samples into
// fixed-length frames and writes a frame only when the FIFO has room for all of it.
module fft_frame_writer #(
  parameter int unsigned SAMPLE_WIDTH     = 16,
  parameter int unsigned FRAME_LEN_LOG2   = 8,
  parameter int unsigned FIFO_DEPTH_WIDTH = 11
) (
  input  logic                        clk_write,
  input  logic                        rst_n,
  input  logic                        enable_i,
  input  logic                        in_valid_i,
  input  logic [SAMPLE_WIDTH-1:0]     in_data_i,
  input  logic                        fifo_full_i,
  input  logic [FIFO_DEPTH_WIDTH-1:0] fifo_count_i,
  output logic                        fifo_write_o,
  output logic [SAMPLE_WIDTH:0]       fifo_data_o,
  output logic [15:0]                 frames_written_o,
  output logic [15:0]                 frames_dropped_o,
  output logic                        overrun_o,
  output logic                        busy_o
);

  localparam int unsigned FrameLen = 2 ** FRAME_LEN_LOG2;
  localparam logic [FIFO_DEPTH_WIDTH:0] DepthWords = {1'b1, {FIFO_DEPTH_WIDTH{1'b0}}};
  // Two words of margin: the FIFO count lags by a cycle and our output register holds one more.
  localparam logic [FIFO_DEPTH_WIDTH:0] RoomNeeded = (FIFO_DEPTH_WIDTH + 1)'(FrameLen + 2);
  localparam logic [FRAME_LEN_LOG2-1:0] IdxOne = FRAME_LEN_LOG2'(1);
  localparam logic [FRAME_LEN_LOG2-1:0] IdxLast = {FRAME_LEN_LOG2{1'b1}};

  typedef enum logic [1:0] {StIdle, StArm, StWrite, StDrop} state_e;

  state_e                    state_q;
  logic [FRAME_LEN_LOG2-1:0] idx_q;
  logic                      fifo_write_q;
  logic [SAMPLE_WIDTH:0]     fifo_data_q;
  logic [15:0]               frames_written_q;
  logic [15:0]               frames_dropped_q;
  logic                      overrun_q;
  logic                      busy_q;

  logic [FIFO_DEPTH_WIDTH:0] free_words;
  logic                      room_ok;
  logic                      idx_last;

  // A full FIFO reports count 0, so fifo_full must veto the room check on its own.
  always_comb begin
    free_words = DepthWords - {1'b0, fifo_count_i};
    room_ok    = !fifo_full_i && (free_words >= RoomNeeded);
    idx_last   = (idx_q == IdxLast);
  end

  always_ff @(posedge clk_write or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= StIdle;
      idx_q            <= '0;
      fifo_write_q     <= 1'b0;
      fifo_data_q      <= '0;
      frames_written_q <= '0;
      frames_dropped_q <= '0;
      overrun_q        <= 1'b0;
      busy_q           <= 1'b0;
    end else begin
      fifo_write_q <= 1'b0;
      // The FIFO drops a word written while full; framing carries on regardless.
      if (fifo_write_q && fifo_full_i) begin
        overrun_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (enable_i) begin
            state_q <= StArm;
          end
        end

        StArm: begin
          if (!enable_i) begin
            state_q <= StIdle;
          end else if (in_valid_i) begin
            idx_q  <= IdxOne;
            busy_q <= 1'b1;
            if (room_ok) begin
              fifo_write_q <= 1'b1;
              fifo_data_q  <= {1'b1, in_data_i};
              state_q      <= StWrite;
            end else begin
              state_q <= StDrop;
            end
          end
        end

        StWrite: begin
          if (in_valid_i) begin
            fifo_write_q <= 1'b1;
            fifo_data_q  <= {1'b0, in_data_i};
            idx_q        <= idx_q + IdxOne;
            if (idx_last) begin
              if (frames_written_q != 16'hFFFF) begin
                frames_written_q <= frames_written_q + 16'd1;
              end
              busy_q  <= 1'b0;
              state_q <= enable_i ? StArm : StIdle;
            end
          end
        end

        StDrop: begin
          if (in_valid_i) begin
            idx_q <= idx_q + IdxOne;
            if (idx_last) begin
              if (frames_dropped_q != 16'hFFFF) begin
                frames_dropped_q <= frames_dropped_q + 16'd1;
              end
              busy_q  <= 1'b0;
              state_q <= enable_i ? StArm : StIdle;
            end
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign fifo_write_o     = fifo_write_q;
  assign fifo_data_o      = fifo_data_q;
  assign frames_written_o = frames_written_q;
  assign frames_dropped_o = frames_dropped_q;
  assign overrun_o        = overrun_q;
  assign busy_o           = busy_q;

endmodule

// File: tb/tb_fft_frame_writer.sv
// Bench for fft_frame_writer: table of frame-level vectors plus hand sequences, with a
// scoreboard queue of expected FIFO words checked as the DUT emits them.
module tb_fft_frame_writer;

  logic        clk_write = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        in_valid;
  logic [15:0] in_data;
  logic        fifo_full;
  logic [10:0] fifo_count;
  logic        fifo_write;
  logic [16:0] fifo_data;
  logic [15:0] frames_written;
  logic [15:0] frames_dropped;
  logic        overrun;
  logic        busy;

  fft_frame_writer #(
    .SAMPLE_WIDTH    (16),
    .FRAME_LEN_LOG2  (8),
    .FIFO_DEPTH_WIDTH(11)
  ) dut (
    .clk_write       (clk_write),
    .rst_n           (rst_n),
    .enable_i        (enable),
    .in_valid_i      (in_valid),
    .in_data_i       (in_data),
    .fifo_full_i     (fifo_full),
    .fifo_count_i    (fifo_count),
    .fifo_write_o    (fifo_write),
    .fifo_data_o     (fifo_data),
    .frames_written_o(frames_written),
    .frames_dropped_o(frames_dropped),
    .overrun_o       (overrun),
    .busy_o          (busy)
  );

  always #5 clk_write = ~clk_write;

  typedef struct {
    logic [10:0] count;
    logic        full;
    logic        accept;
    logic [15:0] base;
  } frame_vec_t;

  frame_vec_t  vecs[7];
  logic [16:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fw_exp = 0;
  int          fd_exp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every write pulse must match the oldest expected word.
  always @(negedge clk_write) begin
    if (rst_n && fifo_write) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%0h required=none", fifo_data);
      end else begin
        check("fifo_data", {15'd0, fifo_data}, {15'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_frame(input logic [10:0] count0, input logic full0,
                            input logic [15:0] base, input logic accept,
                            input int en_low_idx, input int full_idx);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk_write);
      #1;
      in_valid   = 1'b1;
      in_data    = 16'(base + i);
      fifo_count = (i == 0) ? count0 : 11'd0;
      fifo_full  = (i == 0) ? full0 : (i == full_idx);
      if (i == en_low_idx) enable = 1'b0;
      if (accept) exp_q.push_back({(i == 0), 16'(base + i)});
    end
    @(posedge clk_write);
    #1;
    in_valid  = 1'b0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clk_write);
    #1;
    if (accept) fw_exp++;
    else fd_exp++;
    check("frame_drained", exp_q.size(), 0);
    check("frames_written", frames_written, fw_exp);
    check("frames_dropped", frames_dropped, fd_exp);
    check("busy_after_frame", busy, 0);
  endtask

  task automatic rearm();
    enable = 1'b1;
    repeat (2) @(posedge clk_write);
    #1;
  endtask

  initial begin
    // 2048-1790 = 258 free (just enough), 2048-1791 = 257 (one short).
    vecs[0] = '{count: 11'd0,    full: 1'b0, accept: 1'b1, base: 16'h0000};
    vecs[1] = '{count: 11'd1790, full: 1'b0, accept: 1'b1, base: 16'h1000};
    vecs[2] = '{count: 11'd1791, full: 1'b0, accept: 1'b0, base: 16'h2000};
    vecs[3] = '{count: 11'd0,    full: 1'b0, accept: 1'b1, base: 16'h3000};
    vecs[4] = '{count: 11'd0,    full: 1'b1, accept: 1'b0, base: 16'h4000};
    vecs[5] = '{count: 11'd2047, full: 1'b0, accept: 1'b0, base: 16'h4800};
    vecs[6] = '{count: 11'd1024, full: 1'b0, accept: 1'b1, base: 16'hFF80};

    rst_n      = 1'b0;
    enable     = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    fifo_full  = 1'b0;
    fifo_count = '0;
    repeat (3) @(posedge clk_write);
    #1;
    check("rst_fifo_write", fifo_write, 0);
    check("rst_fifo_data", fifo_data, 0);
    check("rst_frames_written", frames_written, 0);
    check("rst_frames_dropped", frames_dropped, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    rst_n = 1'b1;

    // IDLE ignores samples.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_write);
      #1;
      in_valid = 1'b1;
      in_data  = 16'(16'hAA00 + i);
    end
    @(posedge clk_write);
    #1;
    in_valid = 1'b0;
    check("idle_busy", busy, 0);
    rearm();

    for (int v = 0; v < 7; v++) begin
      send_frame(vecs[v].count, vecs[v].full, vecs[v].base, vecs[v].accept, -1, -1);
    end

    // Enable falls at sample 100: frame still completes, then IDLE ignores input.
    send_frame(11'd0, 1'b0, 16'h5000, 1'b1, 100, -1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_write);
      #1;
      in_valid = 1'b1;
      in_data  = 16'(16'hBB00 + i);
    end
    @(posedge clk_write);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk_write);
    #1;
    check("idle_no_writes", exp_q.size(), 0);
    check("idle_frames_written", frames_written, fw_exp);
    rearm();

    // Overrun: one cycle of fifo_full mid-WRITE; frame still completes.
    check("overrun_before", overrun, 0);
    send_frame(11'd0, 1'b0, 16'h6000, 1'b1, -1, 50);
    check("overrun_set", overrun, 1);
    send_frame(11'd5, 1'b0, 16'h7000, 1'b1, -1, -1);
    check("overrun_sticky", overrun, 1);

    // Asynchronous reset in the middle of a written frame.
    for (int i = 0; i < 20; i++) begin
      @(posedge clk_write);
      #1;
      in_valid   = 1'b1;
      in_data    = 16'(16'h8000 + i);
      fifo_count = '0;
      exp_q.push_back({(i == 0), 16'(16'h8000 + i)});
    end
    @(posedge clk_write);
    #1;
    check("mid_busy", busy, 1);
    check("mid_fifo_write", fifo_write, 1);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    in_valid = 1'b0;
    check("arst_fifo_write", fifo_write, 0);
    check("arst_fifo_data", fifo_data, 0);
    check("arst_frames_written", frames_written, 0);
    check("arst_frames_dropped", frames_dropped, 0);
    check("arst_overrun", overrun, 0);
    check("arst_busy", busy, 0);
    repeat (2) @(posedge clk_write);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
